mimo_symbol_encoder: RTL and testbench

- Transmit-side counterpart of the sphere-decoding MIMO detector.
- Accepts a 4×4 upper-triangular channel matrix R and 12-bit Gray-coded symbol vectors, and maps each 3-bit field to the 8-point constellation.
- Computes y = R·s in Q6.10 fixed point.
- Drives the detector's input bus: R rows with flagChannelorData=1, then one y word per symbol vector with flagChannelorData=0, under a valid/ready handshake.

---
 rtl/mimo_pkg.sv | 60 ++++++
 rtl/cmplx_dot4.sv | 74 +++++++
 rtl/mimo_symbol_encoder.sv | 127 ++++++++++++
 tb/tb_mimo_symbol_encoder.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/mimo_pkg.sv
// Shared definitions for the MIMO symbol encoder.
// Holds the Q6.10 width parameters, the complex word type, the 8-point
// constellation, the Gray-inverse helper, the row-arithmetic helpers
// (sign extension, saturation) and the FSM state encodings.
package mimo_pkg;

  localparam int unsigned INT_W  = 6;
  localparam int unsigned FRAC_W = 10;
  localparam int unsigned WIDTH  = INT_W + FRAC_W;
  localparam int unsigned CPLX_W = 2 * WIDTH;        // {re, im}
  localparam int unsigned VEC_W  = 4 * CPLX_W;       // four complex values
  localparam int unsigned ACC_W  = 2 * WIDTH + 3;    // 8 Q12.20 terms summed

  localparam logic signed [ACC_W-1:0] RND_HALF = ACC_W'(2 ** (FRAC_W - 1));
  localparam logic signed [ACC_W-1:0] SAT_MAX  = ACC_W'((2 ** (WIDTH - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN  = ~SAT_MAX;

  typedef struct packed {
    logic signed [WIDTH-1:0] re;
    logic signed [WIDTH-1:0] im;
  } cplx_t;

  // Indexed by k = Gray^-1(u); c = 0x02D4, 1.0 = 0x0400.
  localparam cplx_t CONSTEL [8] = '{
    '{re: 16'hFC00, im: 16'h0000},
    '{re: 16'hFD2C, im: 16'h02D4},
    '{re: 16'h0000, im: 16'h0400},
    '{re: 16'h02D4, im: 16'h02D4},
    '{re: 16'h0400, im: 16'h0000},
    '{re: 16'h02D4, im: 16'hFD2C},
    '{re: 16'h0000, im: 16'hFC00},
    '{re: 16'hFD2C, im: 16'hFD2C}
  };

  typedef logic [2:0] state_t;
  localparam state_t S_LOAD_R   = 3'd0;
  localparam state_t S_SEND_R   = 3'd1;
  localparam state_t S_WAIT_SYM = 3'd2;
  localparam state_t S_COMPUTE  = 3'd3;
  localparam state_t S_SEND_Y   = 3'd4;

  function automatic logic [2:0] gray_inv(input logic [2:0] u);
    return {u[2], u[2] ^ u[1], u[2] ^ u[1] ^ u[0]};
  endfunction

  function automatic cplx_t map_sym(input logic [2:0] u);
    return CONSTEL[gray_inv(u)];
  endfunction

  function automatic logic signed [ACC_W-1:0] sext(input logic signed [WIDTH-1:0] v);
    return {{(ACC_W - WIDTH){v[WIDTH-1]}}, v};
  endfunction

  function automatic logic [WIDTH-1:0] sat16(input logic signed [ACC_W-1:0] v);
    if (v > SAT_MAX) return {1'b0, {(WIDTH - 1){1'b1}}};
    if (v < SAT_MIN) return {1'b1, {(WIDTH - 1){1'b0}}};
    return v[WIDTH-1:0];
  endfunction

endpackage

// File: rtl/cmplx_dot4.sv
// Complex dot product of one R row with the symbol vector s, rounded
// half-up to Q6.10 and saturated, with one output register stage.
// Optional macro MIMO_ENC_NOISE_EN adds LFSR noise (-8..+7 LSB) per component.
// Ports:
//   Clk, Reset  clock, asynchronous active-high reset
//   i_en        a row is being issued (steps the noise LFSR when enabled)
//   i_row       {R[i][0..3]}, MSB first
//   i_sym       {s0..s3}, MSB first
//   o_y         registered y_i = {re, im}
module cmplx_dot4
  import mimo_pkg::*;
(
  input  logic              Clk,
  input  logic              Reset,
  input  logic              i_en,
  input  logic [VEC_W-1:0]  i_row,
  input  logic [VEC_W-1:0]  i_sym,
  output logic [CPLX_W-1:0] o_y
);

  logic signed [ACC_W-1:0] acc_re, acc_im;
  logic signed [ACC_W-1:0] noise_re, noise_im;
  logic signed [ACC_W-1:0] sum_re, sum_im;
  logic [CPLX_W-1:0]       y_q;

  always_comb begin
    cplx_t a, b;
    acc_re = '0;
    acc_im = '0;
    a      = '0;
    b      = '0;
    for (int j = 0; j < 4; j++) begin
      a = i_row[VEC_W-1-CPLX_W*j -: CPLX_W];
      b = i_sym[VEC_W-1-CPLX_W*j -: CPLX_W];
      acc_re = acc_re + sext(a.re) * sext(b.re) - sext(a.im) * sext(b.im);
      acc_im = acc_im + sext(a.re) * sext(b.im) + sext(a.im) * sext(b.re);
    end
  end

`ifdef MIMO_ENC_NOISE_EN
  logic [15:0] lfsr_q, lfsr_1, lfsr_2;

  // x^16 + x^14 + x^13 + x^11 + 1, shifting right.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction

  assign lfsr_1   = lfsr_step(lfsr_q);
  assign lfsr_2   = lfsr_step(lfsr_1);
  assign noise_re = {{(ACC_W - 4){lfsr_1[3]}}, lfsr_1[3:0]};
  assign noise_im = {{(ACC_W - 4){lfsr_2[3]}}, lfsr_2[3:0]};

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)     lfsr_q <= 16'hACE1;
    else if (i_en) lfsr_q <= lfsr_2;
  end
`else
  logic unused_en;
  assign unused_en = i_en;
  assign noise_re  = '0;
  assign noise_im  = '0;
`endif

  assign sum_re = ((acc_re + RND_HALF) >>> FRAC_W) + noise_re;
  assign sum_im = ((acc_im + RND_HALF) >>> FRAC_W) + noise_im;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) y_q <= '0;
    else       y_q <= {sat16(sum_re), sat16(sum_im)};
  end

  assign o_y = y_q;

endmodule

// File: rtl/mimo_symbol_encoder.sv
// Transmit-side MIMO encoder: stores a 4x4 channel matrix R, echoes its rows
// to the detector (o_flag=1), then for each 12-bit Gray-coded symbol vector
// emits y = R*s in Q6.10 (o_flag=0).
// Optional macro MIMO_ENC_NOISE_EN (in cmplx_dot4) adds LFSR noise to y.
// Ports:
//   Clk, Reset                       clock, asynchronous active-high reset
//   i_ch_valid/i_ch_data/o_ch_ready  R row input handshake, rows 0..3 in order
//   i_sym_valid/i_sym/o_sym_ready    symbol vector handshake, {u3,u2,u1,u0}
//   o_valid/o_flag/o_data/i_ready    detector output handshake
module mimo_symbol_encoder
  import mimo_pkg::*;
(
  input  logic             Clk,
  input  logic             Reset,
  input  logic             i_ch_valid,
  input  logic [VEC_W-1:0] i_ch_data,
  output logic             o_ch_ready,
  input  logic             i_sym_valid,
  input  logic [11:0]      i_sym,
  output logic             o_sym_ready,
  output logic             o_valid,
  output logic             o_flag,
  output logic [VEC_W-1:0] o_data,
  input  logic             i_ready
);

  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [VEC_W-1:0]  r_q [4];
  logic [11:0]       sym_q;
  logic [CPLX_W-1:0] y_q [4];
  logic [VEC_W-1:0]  s_vec;
  logic [CPLX_W-1:0] dot_y;
  logic              dot_en;
  logic [1:0]        row_idx, y_idx;

  // cnt_q indexes rows while loading/sending and sequences the compute pass;
  // the dot-product result lags the issued row by one cycle.
  assign row_idx = cnt_q[1:0];
  assign y_idx   = cnt_q[1:0] - 2'd1;
  assign dot_en  = (state_q == S_COMPUTE) && !cnt_q[2];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_LOAD_R: if (i_ch_valid) begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd3) begin
          state_d = S_SEND_R;
          cnt_d   = '0;
        end
      end
      S_SEND_R: if (i_ready) begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd3) begin
          state_d = S_WAIT_SYM;
          cnt_d   = '0;
        end
      end
      S_WAIT_SYM: begin
        cnt_d = '0;
        if (i_sym_valid)     state_d = S_COMPUTE;
        else if (i_ch_valid) state_d = S_LOAD_R;
      end
      S_COMPUTE: begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd4) begin
          state_d = S_SEND_Y;
          cnt_d   = '0;
        end
      end
      S_SEND_Y: if (i_ready) state_d = S_WAIT_SYM;
      default: begin
        state_d = S_LOAD_R;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= S_LOAD_R;
      cnt_q   <= '0;
      sym_q   <= '0;
      for (int i = 0; i < 4; i++) begin
        r_q[i] <= '0;
        y_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == S_LOAD_R && i_ch_valid)   r_q[row_idx] <= i_ch_data;
      if (state_q == S_WAIT_SYM && i_sym_valid) sym_q <= i_sym;
      if (state_q == S_COMPUTE && cnt_q != 3'd0) y_q[y_idx] <= dot_y;
    end
  end

  always_comb begin
    s_vec = '0;
    for (int j = 0; j < 4; j++) begin
      s_vec[VEC_W-1-CPLX_W*j -: CPLX_W] = map_sym(sym_q[3*j +: 3]);
    end
  end

  cmplx_dot4 u_dot (
    .Clk   (Clk),
    .Reset (Reset),
    .i_en  (dot_en),
    .i_row (r_q[row_idx]),
    .i_sym (s_vec),
    .o_y   (dot_y)
  );

  assign o_ch_ready  = (state_q == S_LOAD_R);
  assign o_sym_ready = (state_q == S_WAIT_SYM);
  assign o_valid     = (state_q == S_SEND_R) || (state_q == S_SEND_Y);
  assign o_flag      = (state_q == S_SEND_R);

  // Outputs decode from held registers, so they stay put while stalled.
  always_comb begin
    o_data = '0;
    if (state_q == S_SEND_R)      o_data = r_q[row_idx];
    else if (state_q == S_SEND_Y) o_data = {y_q[0], y_q[1], y_q[2], y_q[3]};
  end

endmodule

// File: tb/tb_mimo_symbol_encoder.sv
// Directed self-checking bench for mimo_symbol_encoder (noise feature off).
module tb_mimo_symbol_encoder;

  logic         Clk = 1'b0;
  logic         Reset;
  logic         i_ch_valid;
  logic [127:0] i_ch_data;
  logic         o_ch_ready;
  logic         i_sym_valid;
  logic [11:0]  i_sym;
  logic         o_sym_ready;
  logic         o_valid;
  logic         o_flag;
  logic [127:0] o_data;
  logic         i_ready;

  int n_checks = 0;
  int n_errors = 0;

  logic [127:0] r_id  [4];
  logic [127:0] r_two [4];
  logic [127:0] r_sat [4];

  always #5 Clk = ~Clk;

  mimo_symbol_encoder dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .i_ch_valid  (i_ch_valid),
    .i_ch_data   (i_ch_data),
    .o_ch_ready  (o_ch_ready),
    .i_sym_valid (i_sym_valid),
    .i_sym       (i_sym),
    .o_sym_ready (o_sym_ready),
    .o_valid     (o_valid),
    .o_flag      (o_flag),
    .o_data      (o_data),
    .i_ready     (i_ready)
  );

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic load_r(input logic [127:0] rows [4]);
    for (int i = 0; i < 4; i++) begin
      int w;
      w          = 0;
      i_ch_valid = 1'b1;
      i_ch_data  = rows[i];
      while (!o_ch_ready && w < 10) begin
        @(negedge Clk);
        w++;
      end
      check_eq("ch_ready", 128'(o_ch_ready), 128'(1));
      @(negedge Clk);
    end
    i_ch_valid = 1'b0;
    i_ch_data  = '0;
  endtask

  task automatic recv_rows(input logic [127:0] rows [4], input int stall);
    i_ready = 1'b0;
    for (int s = 0; s < stall; s++) begin
      check_eq("stall_vf", 128'({o_valid, o_flag}), 128'(2'b11));
      check_eq("stall_data", o_data, rows[0]);
      @(negedge Clk);
    end
    i_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_eq("row_vf", 128'({o_valid, o_flag}), 128'(2'b11));
      check_eq("row_data", o_data, rows[i]);
      @(negedge Clk);
    end
    check_eq("wait_sym_ready", 128'(o_sym_ready), 128'(1));
  endtask

  task automatic send_sym(input logic [11:0] sym, input logic [127:0] exp);
    int lat;
    check_eq("sym_ready", 128'(o_sym_ready), 128'(1));
    i_sym_valid = 1'b1;
    i_sym       = sym;
    @(negedge Clk);
    i_sym_valid = 1'b0;
    i_sym       = '0;
    lat         = 1;
    while (!o_valid && lat < 20) begin
      @(negedge Clk);
      lat++;
    end
    check_eq("y_latency", 128'(lat), 128'(6));
    check_eq("y_flag", 128'(o_flag), 128'(0));
    check_eq("y_data", o_data, exp);
    @(negedge Clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    for (int i = 0; i < 4; i++) begin
      r_id[i]  = '0;
      r_sat[i] = {4{32'h7C00_0000}};
    end
    r_id[0] = {32'h0400_0000, 96'h0};
    r_id[1] = {32'h0, 32'h0400_0000, 64'h0};
    r_id[2] = {64'h0, 32'h0400_0000, 32'h0};
    r_id[3] = {96'h0, 32'h0400_0000};
    // Includes an imaginary entry and lower-triangle entries.
    r_two[0] = {32'h0400_0000, 32'h0000_0400, 64'h0};
    r_two[1] = {32'h0200_0000, 32'h0400_0000, 64'h0};
    r_two[2] = {32'h0080_0000, 96'h0};
    r_two[3] = {96'h0, 32'h0080_0000};

    Reset       = 1'b1;
    i_ch_valid  = 1'b0;
    i_ch_data   = '0;
    i_sym_valid = 1'b0;
    i_sym       = '0;
    i_ready     = 1'b1;
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    check_eq("rst_valid", 128'(o_valid), 128'(0));
    check_eq("rst_flag", 128'(o_flag), 128'(0));
    check_eq("rst_data", o_data, 128'(0));
    check_eq("rst_sym_ready", 128'(o_sym_ready), 128'(0));
    check_eq("rst_ch_ready", 128'(o_ch_ready), 128'(1));

    // Identity R, stalled row 0 for 5 cycles.
    load_r(r_id);
    recv_rows(r_id, 5);
    send_sym(12'h000, {4{32'hFC00_0000}});
    send_sym(12'h492, {4{32'h02D4_02D4}});
    send_sym(12'h999, {32'hFD2C_02D4, 32'h0000_0400, 32'h0400_0000, 32'hFD2C_FD2C});

    // Row and symbol offered together: symbol uses old R, then R reloads.
    i_ch_valid = 1'b1;
    i_ch_data  = r_two[0];
    send_sym(12'h000, {4{32'hFC00_0000}});
    load_r(r_two);
    recv_rows(r_two, 0);
    // Exercises half-LSB rounding in both directions.
    send_sym(12'h999, {32'hF92C_02D4, 32'hFE96_056A, 32'hFFA6_005B, 32'hFFA6_FFA6});

    // Saturation both ways.
    load_r(r_sat);
    recv_rows(r_sat, 0);
    send_sym(12'h924, {4{32'h8000_8000}});
    send_sym(12'hDB6, {4{32'h7FFF_0000}});

    // Reset in the middle of a compute pass.
    check_eq("pre_rst_sym_ready", 128'(o_sym_ready), 128'(1));
    i_sym_valid = 1'b1;
    i_sym       = 12'h492;
    @(negedge Clk);
    i_sym_valid = 1'b0;
    repeat (2) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    check_eq("midrst_valid", 128'(o_valid), 128'(0));
    check_eq("midrst_ch_ready", 128'(o_ch_ready), 128'(1));
    check_eq("midrst_sym_ready", 128'(o_sym_ready), 128'(0));
    Reset = 1'b0;
    seen  = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge Clk);
      if (o_valid) seen++;
    end
    check_eq("midrst_no_y", 128'(seen), 128'(0));

    load_r(r_id);
    recv_rows(r_id, 0);
    send_sym(12'h492, {4{32'h02D4_02D4}});

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
